seq_wide_adder: RTL
===================

Name: seq_wide_adder

Overview:
- Multi-cycle wide-operand adder that sits directly upstream of the 16-bit ripple adder datapath.
- Accepts one WORDS×16-bit add request over a valid/ready handshake.
- Slices the operands into 16-bit words and feeds them LSW-first to an internal 16-bit adder, one word per cycle, chaining each carry-out into the next cycle's carry-in.
- Collects the partial sums into a registered wide result returned over a second valid/ready handshake.

Parameters:
- WORDS, 4, number of 16-bit words per operand (legal 2..8); operand width W = 16*WORDS.
- IDXW, 3, width of the word-index counter; must satisfy 2**IDXW >= WORDS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in to word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  registered result.
- cout  output  1  carry-out of the most significant word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0; in_ready=1 once rst deasserts.
- State machine, IDLE / RUN / DONE:
  - IDLE:
    - in_ready=1.
    - On edge with in_valid&in_ready: latch a, b into op registers, carry<=cin, idx<=0, state<=RUN.
    - in_valid while not in IDLE is ignored; the request is held by the producer.
  - RUN:
    - in_ready=0.
    - Each edge: word idx of a and b plus carry goes through the 16-bit adder; sum[16*idx+15:16*idx] <= adder sum; carry <= adder carry-out; idx <= idx+1.
    - On the edge processing idx==WORDS-1: cout <= adder carry-out, out_valid <= 1, state <= DONE.
  - DONE:
    - sum, cout and out_valid are held stable until out_valid&out_ready.
    - On that edge: out_valid <= 0, state <= IDLE. in_ready rises in the following cycle; there is no same-cycle turnaround.
- Latency:
  - Accept edge E0; out_valid is high after edge E0+WORDS (4 cycles at default).
  - Throughput is one request per WORDS+2 cycles, with out_ready held high.
- Arithmetic:
  - Result is the unsigned sum {cout,sum} = a + b + cin, exact modulo 2**(W+1); no saturation.
  - Intermediate carry lives only in the carry register.
- sum contents while in RUN:
  - sum is only valid while out_valid=1.
  - During RUN, words not yet computed keep their previous values; the consumer must not sample them.
- Operand stability: a and b are sampled only at the accept edge. Later changes on the inputs do not affect the result in flight.
- Reset mid-operation: rst in RUN or DONE discards the request immediately and returns all outputs to reset values asynchronously.
- Boundary cases:
  - all-ones + 1 → sum=0, cout=1.
  - 0 + 0 with cin=1 → sum=1, cout=0.
  - out_ready held low indefinitely → block stays in DONE with outputs stable.

Optional Feature:
- Macro: SEQ_WIDE_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), sampled at the accept edge.
  - With sub=1, the block computes a + ~b + 1: every B word is inverted before the adder, and cin is ignored with the initial carry forced to 1.
  - cout is then the no-borrow flag (1 when a >= b unsigned).
- When undefined:
  - No sub port.
  - Addition only, exactly as specified above.

Test Plan:
- Reset, then a=64'h0000_0000_0000_0003, b=64'h0000_0000_0000_0004, cin=0 accepted at edge E0 → out_valid=1 after edge E0+4, sum=64'h7, cout=0.
- Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=64'h1, cin=0 → sum=64'h0, cout=1; same operands with b=0, cin=1 → same result.
- Backpressure: out_ready=0 for 10 cycles after out_valid → sum, cout and out_valid unchanged, in_ready=0; raise out_ready → out_valid falls next edge, in_ready=1 the cycle after.
- Reset mid-operation: assert rst two cycles after accept → out_valid=0, sum=0, busy=0 immediately. A new request a=64'h10, b=64'h20 then yields sum=64'h30.
- Back-to-back random requests: 200 random (a, b, cin) with in_valid held high and out_ready=1 → every result matches the reference model; exactly one result per accepted request; operand changes after accept have no effect.
- With SEQ_WIDE_ADDER_SUB_EN: sub=1, a=64'h5, b=64'h7 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0; a=64'h7, b=64'h5 → sum=64'h2, cout=1.

Source files
------------

// File: rtl/seq_wide_adder.sv
// Multi-cycle wide adder: WORDS x 16-bit operands summed LSW-first through one 16-bit adder.
// Optional subtract mode under `SEQ_WIDE_ADDER_SUB_EN` adds a 'sub' input (a + ~b + 1).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// The producer must hold valid and data stable until then. in_ready is high only in IDLE,
// and out_valid stays high with sum/cout stable until out_ready is seen.
module seq_wide_adder #(
    parameter int WORDS = 4,
    parameter int IDXW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   a,
    input  logic [16*WORDS-1:0]   b,
    input  logic                  cin,
`ifdef SEQ_WIDE_ADDER_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);

    localparam int W = 16 * WORDS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            out_valid_q, out_valid_d;

    logic [15:0]     a_word;
    logic [15:0]     b_word;
    logic [16:0]     add_res;
    logic [W-1:0]    b_eff;
    logic            cin_eff;

    // Subtraction inverts B once at accept time so the datapath stays add-only.
`ifdef SEQ_WIDE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == i[IDXW-1:0]) begin
                a_word = op_a_q[16*i +: 16];
                b_word = op_b_q[16*i +: 16];
            end
        end
        add_res = {1'b0, a_word} + {1'b0, b_word} + {16'b0, carry_q};
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_a_d  = a;
                    op_b_d  = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == i[IDXW-1:0]) begin
                        sum_d[16*i +: 16] = add_res[15:0];
                    end
                end
                carry_d = add_res[16];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d      = add_res[16];
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE) && !rst;
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = out_valid_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign dbg_state_o = state_q;

endmodule
